music_sequencer: RTL
====================

// Module: music_sequencer
// PURPOSE
// - Playback controller for the buzzer tone generator. Walks a song ROM one note per
//   step and times each note (gap, then sound). Drives note code + gate to the
//   generator, which maps the code to a half-period count and toggles pwm.
// - Handles song select, start, pause, loop and end-of-song.
// - Sits between the board-level mode switches/buttons and the tone generator.
// PARAMETERS
// - ADDR_W   8           song ROM address width; 4 songs of 2^(ADDR_W-2) entries each
// - NOTE_W   6           note code width; code 0 = rest
// - TICK_16  12_500_000  cycles per 16th-note step (0.125 s @ 100 MHz)
// - GAP_16   2_500_000   silent lead-in cycles per 16th step; must be < TICK_16
// PORTS
// - clk         in   1       system clock, 100 MHz
// - rst         in   1       asynchronous reset, active-high
// - song_sel    in   3       one-hot song select (001/010/100 -> song 0/1/2)
// - start       in   1       1-cycle pulse: (re)start selected song from its first entry
// - pause       in   1       level: freeze timing and mute while high
// - loop_en     in   1       1 = restart song at end marker instead of stopping
// - rom_addr    out  ADDR_W  song ROM address (sync ROM, data valid 1 cycle later)
// - rom_data    in   8       [7:6] dur (00=16th, 01=8th, 10=quarter, 11=END); [5:0] note
// - note        out  NOTE_W  note code to tone generator (held through gap and sound)
// - note_valid  out  1       gate: tone generator sounds only when high
// - busy        out  1       high in every state except IDLE
// - done        out  1       1-cycle pulse on non-looping end of song
// BEHAVIOUR
// - Reset (async, any state): state=IDLE; rom_addr=0, note=0, note_valid=0, busy=0, done=0.
// - Song base address = song_index << (ADDR_W-2).
//   - song_sel not one-hot in IDLE: start is ignored.
//   - song_sel not one-hot in any other state: forces IDLE.
// - States and transitions:
//   - IDLE  : on start with valid song_sel: rom_addr<=base, go FETCH.
//   - FETCH : ROM address presented; next cycle go DECODE.
//   - DECODE: rom_data is valid this cycle. Register note and mult (1/2/4 for dur 00/01/10).
//     - dur==11, loop_en=1: rom_addr<=base, go FETCH.
//     - dur==11, loop_en=0: pulse done, go IDLE.
//     - otherwise: load timer with GAP_16*mult-1, go GAP.
//   - GAP   : note_valid=0. On timer expiry: load (TICK_16-GAP_16)*mult-1, go SOUND.
//   - SOUND : note_valid=1 unless note==0 (rest).
//     - On expiry: rom_addr<=rom_addr+1, go FETCH.
//     - If rom_addr is the last entry of the song's region: treat as END (loop or done).
// - Note period in steady play = mult*TICK_16 + 2 cycles (FETCH + DECODE overhead).
// - pause=1 in GAP/SOUND: timer holds and note_valid=0.
//   - On release: resume with the remaining count; no cycles are lost.
//   - pause=1 in FETCH/DECODE: fetch completes, then the block holds in GAP.
// - start while busy: restart the current song_sel from base, same as from IDLE.
//   - note_valid=0 from the next cycle.
// - song_sel change while busy (to a different one-hot value): abort to IDLE.
//   - note_valid=0 next cycle; no done pulse.
//   - If start is asserted in the same cycle: restart with the new song (start wins).
// - note_valid is registered: it changes exactly on the GAP->SOUND and SOUND->FETCH edges.
// - Timer arithmetic is 32-bit unsigned. A mult*TICK_16 product that overflows 32 bits
//   is illegal.
// STRUCTURE
// - Shared package music_pkg:
//   - DUR_16/DUR_8/DUR_4/DUR_END codes.
//   - Note-code constants (do_low..si, codes 1..14) and their half-period table, shared
//     with the tone generator.
//   - State encoding localparams.
// - Sub-module note_timer: 32-bit down counter.
//   - Inputs: load, load_val, en. Output: expire (count==0 && en).
// - Top: FSM + address register + note/mult registers.
// TESTING (sim with TICK_16=10, GAP_16=2, ADDR_W=6)
// - Reset mid-SOUND with note_valid=1 -> note_valid=0, busy=0, rom_addr=0 same cycle
//   (async).
// - song 001, ROM {00:note 8, 01:note 9, 11:END}, start ->
//   - note 8: gate low 2 cycles, then high 8 cycles.
//   - note 9: gate low 4 cycles, then high 16 cycles.
//   - Then done pulses once, busy=0.
// - Same ROM, loop_en=1 -> after END, rom_addr returns to 0, note 8 replays; done never
//   pulses.
// - pause high 5 cycles midway through note 8 SOUND -> gate low for 5 cycles; SOUND total
//   stays 8 high cycles.
// - Rest entry {10:note 0} -> gate stays low for the full 40 cycles; rom_addr still
//   advances.
// - song_sel 001->010 while busy (no start) -> IDLE next cycle, gate 0, done 0.
//   - Then start -> rom_addr=16.

Source files
------------

// File: rtl/music_pkg.sv
// Shared definitions for the buzzer playback path: duration codes, note codes,
// the note-to-half-period table used by the tone generator, and FSM encoding.
package music_pkg;

    localparam int unsigned TIMER_W     = 32;
    localparam int unsigned NOTE_CODE_W = 6;
    localparam int unsigned DUR_W       = 2;

    localparam logic [DUR_W-1:0] DUR_16  = 2'b00;
    localparam logic [DUR_W-1:0] DUR_8   = 2'b01;
    localparam logic [DUR_W-1:0] DUR_4   = 2'b10;
    localparam logic [DUR_W-1:0] DUR_END = 2'b11;

    localparam logic [NOTE_CODE_W-1:0] NOTE_REST    = 6'd0;
    localparam logic [NOTE_CODE_W-1:0] NOTE_DO_LOW  = 6'd1;
    localparam logic [NOTE_CODE_W-1:0] NOTE_RE_LOW  = 6'd2;
    localparam logic [NOTE_CODE_W-1:0] NOTE_MI_LOW  = 6'd3;
    localparam logic [NOTE_CODE_W-1:0] NOTE_FA_LOW  = 6'd4;
    localparam logic [NOTE_CODE_W-1:0] NOTE_SOL_LOW = 6'd5;
    localparam logic [NOTE_CODE_W-1:0] NOTE_LA_LOW  = 6'd6;
    localparam logic [NOTE_CODE_W-1:0] NOTE_SI_LOW  = 6'd7;
    localparam logic [NOTE_CODE_W-1:0] NOTE_DO      = 6'd8;
    localparam logic [NOTE_CODE_W-1:0] NOTE_RE      = 6'd9;
    localparam logic [NOTE_CODE_W-1:0] NOTE_MI      = 6'd10;
    localparam logic [NOTE_CODE_W-1:0] NOTE_FA      = 6'd11;
    localparam logic [NOTE_CODE_W-1:0] NOTE_SOL     = 6'd12;
    localparam logic [NOTE_CODE_W-1:0] NOTE_LA      = 6'd13;
    localparam logic [NOTE_CODE_W-1:0] NOTE_SI      = 6'd14;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_GAP    = 3'd3,
        ST_SOUND  = 3'd4
    } state_t;

    // Half-period in 100 MHz cycles (C4..B5); rest and unknown codes give 0.
    function automatic logic [TIMER_W-1:0] half_period(input logic [NOTE_CODE_W-1:0] code);
        case (code)
            NOTE_DO_LOW:  half_period = 32'd191113;
            NOTE_RE_LOW:  half_period = 32'd170264;
            NOTE_MI_LOW:  half_period = 32'd151685;
            NOTE_FA_LOW:  half_period = 32'd143172;
            NOTE_SOL_LOW: half_period = 32'd127551;
            NOTE_LA_LOW:  half_period = 32'd113636;
            NOTE_SI_LOW:  half_period = 32'd101239;
            NOTE_DO:      half_period = 32'd95557;
            NOTE_RE:      half_period = 32'd85132;
            NOTE_MI:      half_period = 32'd75843;
            NOTE_FA:      half_period = 32'd71586;
            NOTE_SOL:     half_period = 32'd63776;
            NOTE_LA:      half_period = 32'd56818;
            NOTE_SI:      half_period = 32'd50619;
            default:      half_period = 32'd0;
        endcase
    endfunction

    // Length multiplier in 16th steps; END maps to 1 and is never timed.
    function automatic logic [2:0] dur_mult(input logic [DUR_W-1:0] dur);
        case (dur)
            DUR_8:   dur_mult = 3'd2;
            DUR_4:   dur_mult = 3'd4;
            default: dur_mult = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/note_timer.sv
// 32-bit down counter timing the gap and sound phases of a note.
module note_timer
    import music_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               en,
    output logic               expire
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - TIMER_W'(1);
        end
    end

    assign expire = en && (count == '0);

endmodule

// File: rtl/music_sequencer.sv
// Song playback controller: walks a song ROM and gates note codes to the tone
// generator with a silent lead-in gap before each sounding note.
module music_sequencer
    import music_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned NOTE_W  = 6,
    parameter int unsigned TICK_16 = 12_500_000,
    parameter int unsigned GAP_16  = 2_500_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        song_sel,
    input  logic              start,
    input  logic              pause,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [NOTE_W-1:0] note,
    output logic              note_valid,
    output logic              busy,
    output logic              done
);

    localparam int unsigned OFF_W = ADDR_W - 2;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [NOTE_W-1:0]   note_n;
    logic [2:0]          mult, mult_n;
    logic [1:0]          song, song_n;
    logic                note_valid_n, busy_n, done_n;

    logic                sel_ok;
    logic [1:0]          sel_idx;
    logic [ADDR_W-1:0]   sel_base, song_base;
    logic                last_entry, at_end;
    logic [DUR_W-1:0]    dec_dur;
    logic [2:0]          dec_mult;
    logic                tmr_load, tmr_en, tmr_expire;
    logic [TIMER_W-1:0]  tmr_val;

    assign sel_ok     = (song_sel == 3'b001) || (song_sel == 3'b010) || (song_sel == 3'b100);
    assign sel_idx    = song_sel[2] ? 2'd2 : (song_sel[1] ? 2'd1 : 2'd0);
    assign sel_base   = {sel_idx, {OFF_W{1'b0}}};
    assign song_base  = {song, {OFF_W{1'b0}}};
    assign last_entry = &rom_addr[OFF_W-1:0];
    assign dec_dur    = rom_data[7:6];
    assign dec_mult   = dur_mult(dec_dur);

    note_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            rom_addr   <= '0;
            note       <= '0;
            mult       <= 3'd1;
            song       <= 2'd0;
            note_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            rom_addr   <= addr_n;
            note       <= note_n;
            mult       <= mult_n;
            song       <= song_n;
            note_valid <= note_valid_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

    always_comb begin
        state_n      = state;
        addr_n       = rom_addr;
        note_n       = note;
        mult_n       = mult;
        song_n       = song;
        note_valid_n = 1'b0;
        done_n       = 1'b0;
        at_end       = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        tmr_en       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start && sel_ok) begin
                    addr_n  = sel_base;
                    song_n  = sel_idx;
                    state_n = ST_FETCH;
                end
            end
            ST_FETCH: state_n = ST_DECODE;
            ST_DECODE: begin
                note_n = NOTE_W'(rom_data[5:0]);
                mult_n = dec_mult;
                if (dec_dur == DUR_END) begin
                    at_end = 1'b1;
                end else begin
                    tmr_load = 1'b1;
                    tmr_val  = 32'(GAP_16) * 32'(dec_mult) - 32'd1;
                    state_n  = ST_GAP;
                end
            end
            ST_GAP: begin
                tmr_en = !pause;
                if (tmr_expire) begin
                    tmr_load     = 1'b1;
                    tmr_val      = 32'(TICK_16 - GAP_16) * 32'(mult) - 32'd1;
                    note_valid_n = (note != '0);
                    state_n      = ST_SOUND;
                end
            end
            ST_SOUND: begin
                tmr_en       = !pause;
                note_valid_n = (note != '0) && !pause;
                if (tmr_expire) begin
                    note_valid_n = 1'b0;
                    if (last_entry) begin
                        at_end = 1'b1;
                    end else begin
                        addr_n  = rom_addr + ADDR_W'(1);
                        state_n = ST_FETCH;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (at_end) begin
            if (loop_en) begin
                addr_n  = song_base;
                state_n = ST_FETCH;
            end else begin
                done_n  = 1'b1;
                state_n = ST_IDLE;
            end
        end

        // Select/start overrides: bad select aborts, start restarts, a new song aborts.
        if (state != ST_IDLE) begin
            if (!sel_ok || (!start && (sel_idx != song))) begin
                state_n      = ST_IDLE;
                note_valid_n = 1'b0;
                done_n       = 1'b0;
            end else if (start) begin
                addr_n       = sel_base;
                song_n       = sel_idx;
                state_n      = ST_FETCH;
                note_valid_n = 1'b0;
                done_n       = 1'b0;
            end
        end

        busy_n = (state_n != ST_IDLE);
    end

endmodule
